// File: rtl/ycbcr422_packer.sv
// ycbcr422_packer
//
// Purpose:
//    Converts the decoded 24-bit RGB pixel stream into YCbCr 4:2:2 words for
//    the pixel FIFO drained by datacontroller. Each 29-bit word carries the
//    pixel's horizontal block index, line number, luma and one chroma sample.
//    Pixels pair as (even col, odd col). The even word carries the averaged Cr
//    and the odd word carries the averaged Cb. A trailing unpaired even pixel
//    goes out alone with its own Cr. Words that meet a full FIFO are dropped,
//    never stalled, and the drop is flagged until the next frame start.
//
// Ports:
//    i_clk_74M    74.25 MHz pixel clock, the only clock
//    i_rst_n      synchronous active-low reset
//    i_de         data enable, high during active pixels
//    i_vsync      vertical sync, a rising edge marks frame start
//    i_r/i_g/i_b  8-bit pixel components, valid while i_de is high
//    i_fifo_full  downstream FIFO full
//    o_fifo_wr    FIFO write strobe
//    o_fifo_din   {x_count[1:0], y_count[10:0], Y[7:0], C[7:0]}
//    o_overflow   sticky: a word was dropped during this frame
//
// Pipeline: S1 input register, S2a products/sums, S2b shift/offset/clip,
// S3 pair hold register followed by the output register. A pixel sampled at
// edge t is written after edge t+4.

module ycbcr422_packer #(
   parameter int H_BLOCK = 640
) (
   input  logic        i_clk_74M,
   input  logic        i_rst_n,
   input  logic        i_de,
   input  logic        i_vsync,
   input  logic [7:0]  i_r,
   input  logic [7:0]  i_g,
   input  logic [7:0]  i_b,
   input  logic        i_fifo_full,
   output logic        o_fifo_wr,
   output logic [28:0] o_fifo_din,
   output logic        o_overflow
);

   localparam logic [10:0] BLK_LAST = 11'(H_BLOCK - 1);
   localparam logic [10:0] CNT_MAX  = 11'd2047;

   // S1 registers
   logic        armed_q;
   logic        s1De_q, s1Vs_q;
   logic [7:0]  s1R_q, s1G_q, s1B_q;
   logic        deDly_q, vsDly_q;

   // Counters
   logic [10:0] col_q, col_d;
   logic [10:0] blkPos_q, blkPos_d;
   logic [1:0]  blk_q, blk_d;
   logic [10:0] line_q, line_d;

   // S2a registers
   logic               s2aValid_q, s2aOdd_q;
   logic [1:0]         s2aX_q;
   logic [10:0]        s2aLine_q;
   logic signed [17:0] s2aSumY_q, s2aSumCb_q, s2aSumCr_q;

   // S2b registers
   logic        s2bValid_q, s2bOdd_q;
   logic [1:0]  s2bX_q;
   logic [10:0] s2bLine_q;
   logic [7:0]  s2bLuma_q, s2bCb_q, s2bCr_q;

   // S3 hold register
   logic        holdValid_q, holdValid_d;
   logic        holdEven_q, holdEven_d;
   logic [1:0]  holdX_q, holdX_d;
   logic [10:0] holdLine_q, holdLine_d;
   logic [7:0]  holdLuma_q, holdLuma_d;
   logic [7:0]  holdC_q, holdC_d;
   logic [7:0]  holdCb_q, holdCb_d;

   // Output registers
   logic        wr_q, wr_d;
   logic [28:0] din_q, din_d;
   logic        ovf_q, ovf_d;

   // Combinational helpers
   logic               deRise, deFall, vsRise;
   logic [10:0]        pixCol, pixBlkPos;
   logic [1:0]         pixBlk;
   logic               colSat;
   logic signed [17:0] rExt, gExt, bExt;
   logic signed [17:0] sumY_d, sumCb_d, sumCr_d;
   logic signed [17:0] lumaVal, cbVal, crVal;
   logic               pairNow;
   logic [8:0]         cbSum, crSum;
   logic [7:0]         outC;
   logic [28:0]        outWord;

   function automatic logic [7:0] clip8(input logic signed [17:0] v);
      if (v < 18'sd0) begin
         return 8'd0;
      end else if (v > 18'sd255) begin
         return 8'd255;
      end else begin
         return v[7:0];
      end
   endfunction

   // Input stage. armed_q stays low after reset until i_de is seen low, and
   // gates the data enable so that a line already in progress at reset never
   // produces edges, pixels or line increments.
   always_ff @(posedge i_clk_74M) begin
      if (!i_rst_n) begin
         armed_q <= 1'b0;
         s1De_q  <= 1'b0;
         s1Vs_q  <= 1'b0;
         s1R_q   <= 8'd0;
         s1G_q   <= 8'd0;
         s1B_q   <= 8'd0;
         deDly_q <= 1'b0;
         vsDly_q <= 1'b0;
      end else begin
         if (!i_de) begin
            armed_q <= 1'b1;
         end
         s1De_q  <= i_de & armed_q;
         s1Vs_q  <= i_vsync;
         s1R_q   <= i_r;
         s1G_q   <= i_g;
         s1B_q   <= i_b;
         deDly_q <= s1De_q;
         vsDly_q <= s1Vs_q;
      end
   end

   assign deRise = s1De_q & ~deDly_q;
   assign deFall = ~s1De_q & deDly_q;
   assign vsRise = s1Vs_q & ~vsDly_q;

   // The counters hold the position of the next pixel. The first pixel of a
   // line ignores them and starts from zero. The block index comes from an
   // intra-block position counter, so no divider is needed. It freezes once
   // the column saturates.
   always_comb begin
      pixCol    = deRise ? 11'd0 : col_q;
      pixBlkPos = deRise ? 11'd0 : blkPos_q;
      pixBlk    = deRise ? 2'd0 : blk_q;
      colSat    = (pixCol == CNT_MAX);
      col_d     = col_q;
      blkPos_d  = blkPos_q;
      blk_d     = blk_q;
      if (s1De_q) begin
         col_d    = colSat ? pixCol : pixCol + 11'd1;
         blkPos_d = pixBlkPos;
         blk_d    = pixBlk;
         if (!colSat) begin
            if (pixBlkPos == BLK_LAST) begin
               blkPos_d = 11'd0;
               blk_d    = (pixBlk == 2'd3) ? 2'd3 : pixBlk + 2'd1;
            end else begin
               blkPos_d = pixBlkPos + 11'd1;
            end
         end
      end
   end

   // The line counter clears at frame start, and that clear takes priority
   // over a coincident end of line.
   always_comb begin
      line_d = line_q;
      if (vsRise) begin
         line_d = 11'd0;
      end else if (deFall && (line_q != CNT_MAX)) begin
         line_d = line_q + 11'd1;
      end
   end

   always_ff @(posedge i_clk_74M) begin
      if (!i_rst_n) begin
         col_q    <= 11'd0;
         blkPos_q <= 11'd0;
         blk_q    <= 2'd0;
         line_q   <= 11'd0;
      end else begin
         col_q    <= col_d;
         blkPos_q <= blkPos_d;
         blk_q    <= blk_d;
         line_q   <= line_d;
      end
   end

   // Colour matrix products, all in signed 18-bit arithmetic.
   assign rExt = {10'd0, s1R_q};
   assign gExt = {10'd0, s1G_q};
   assign bExt = {10'd0, s1B_q};
   assign sumY_d  =  18'sd66 * rExt + 18'sd129 * gExt + 18'sd25 * bExt + 18'sd128;
   assign sumCb_d = -18'sd38 * rExt - 18'sd74 * gExt + 18'sd112 * bExt + 18'sd128;
   assign sumCr_d = 18'sd112 * rExt - 18'sd94 * gExt - 18'sd18 * bExt + 18'sd128;

   // S2a: register the sums together with the pixel's position tags.
   always_ff @(posedge i_clk_74M) begin
      if (!i_rst_n) begin
         s2aValid_q <= 1'b0;
         s2aOdd_q   <= 1'b0;
         s2aX_q     <= 2'd0;
         s2aLine_q  <= 11'd0;
         s2aSumY_q  <= 18'sd0;
         s2aSumCb_q <= 18'sd0;
         s2aSumCr_q <= 18'sd0;
      end else begin
         s2aValid_q <= s1De_q;
         s2aOdd_q   <= pixCol[0];
         s2aX_q     <= pixBlk;
         s2aLine_q  <= line_q;
         s2aSumY_q  <= sumY_d;
         s2aSumCb_q <= sumCb_d;
         s2aSumCr_q <= sumCr_d;
      end
   end

   // Floor shift (arithmetic), offset, then clip to 8 bits.
   assign lumaVal = (s2aSumY_q >>> 8) + 18'sd16;
   assign cbVal   = (s2aSumCb_q >>> 8) + 18'sd128;
   assign crVal   = (s2aSumCr_q >>> 8) + 18'sd128;

   always_ff @(posedge i_clk_74M) begin
      if (!i_rst_n) begin
         s2bValid_q <= 1'b0;
         s2bOdd_q   <= 1'b0;
         s2bX_q     <= 2'd0;
         s2bLine_q  <= 11'd0;
         s2bLuma_q  <= 8'd0;
         s2bCb_q    <= 8'd0;
         s2bCr_q    <= 8'd0;
      end else begin
         s2bValid_q <= s2aValid_q;
         s2bOdd_q   <= s2aOdd_q;
         s2bX_q     <= s2aX_q;
         s2bLine_q  <= s2aLine_q;
         s2bLuma_q  <= clip8(lumaVal);
         s2bCb_q    <= clip8(cbVal);
         s2bCr_q    <= clip8(crVal);
      end
   end

   // An even pixel waiting in the hold register pairs with the odd pixel
   // that is in S2b during the same cycle. The even word leaves with the
   // averaged Cr, and the odd pixel moves into the hold register with the
   // averaged Cb already computed. This keeps one word per clock. An even
   // pixel with no partner behind it leaves with its own Cr. A stray odd
   // pixel (only possible once the column saturates) keeps its own Cb.
   assign pairNow = holdValid_q & holdEven_q & s2bValid_q & s2bOdd_q;
   assign cbSum   = {1'b0, holdCb_q} + {1'b0, s2bCb_q} + 9'd1;
   assign crSum   = {1'b0, holdC_q} + {1'b0, s2bCr_q} + 9'd1;

   always_comb begin
      holdValid_d = s2bValid_q;
      holdEven_d  = holdEven_q;
      holdX_d     = holdX_q;
      holdLine_d  = holdLine_q;
      holdLuma_d  = holdLuma_q;
      holdC_d     = holdC_q;
      holdCb_d    = holdCb_q;
      if (s2bValid_q) begin
         holdX_d    = s2bX_q;
         holdLine_d = s2bLine_q;
         holdLuma_d = s2bLuma_q;
         holdCb_d   = s2bCb_q;
         if (pairNow) begin
            holdEven_d = 1'b0;
            holdC_d    = cbSum[8:1];
         end else if (!s2bOdd_q) begin
            holdEven_d = 1'b1;
            holdC_d    = s2bCr_q;
         end else begin
            holdEven_d = 1'b0;
            holdC_d    = s2bCb_q;
         end
      end
   end

   // A word that meets a full FIFO is dropped. In that case the data output
   // keeps its previous value and the drop sets the sticky flag. A drop in
   // the same cycle as a frame-start clear wins over the clear.
   always_comb begin
      outC    = (holdEven_q && pairNow) ? crSum[8:1] : holdC_q;
      outWord = {holdX_q, holdLine_q, holdLuma_q, outC};
      wr_d    = holdValid_q & ~i_fifo_full;
      din_d   = wr_d ? outWord : din_q;
      ovf_d   = ovf_q;
      if (holdValid_q && i_fifo_full) begin
         ovf_d = 1'b1;
      end else if (vsRise) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk_74M) begin
      if (!i_rst_n) begin
         holdValid_q <= 1'b0;
         holdEven_q  <= 1'b0;
         holdX_q     <= 2'd0;
         holdLine_q  <= 11'd0;
         holdLuma_q  <= 8'd0;
         holdC_q     <= 8'd0;
         holdCb_q    <= 8'd0;
         wr_q        <= 1'b0;
         din_q       <= 29'd0;
         ovf_q       <= 1'b0;
      end else begin
         holdValid_q <= holdValid_d;
         holdEven_q  <= holdEven_d;
         holdX_q     <= holdX_d;
         holdLine_q  <= holdLine_d;
         holdLuma_q  <= holdLuma_d;
         holdC_q     <= holdC_d;
         holdCb_q    <= holdCb_d;
         wr_q        <= wr_d;
         din_q       <= din_d;
         ovf_q       <= ovf_d;
      end
   end

   assign o_fifo_wr  = wr_q;
   assign o_fifo_din = din_q;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_ycbcr422_packer.sv
// tb_ycbcr422_packer
//
// Purpose:
//    Directed bench for ycbcr422_packer. Every FIFO write is logged together
//    with the edge that produced it. Word contents, latencies and write counts
//    are then compared against hand-computed values for colour conversion,
//    pairing, the trailing pixel, block indexing, back-pressure, mid-line
//    reset and line-counter behaviour.

module tb_ycbcr422_packer;

   logic        clk = 1'b0;
   logic        rstN;
   logic        de, vs;
   logic [7:0]  r, g, b;
   logic        full;
   logic        wr;
   logic [28:0] din;
   logic        ovf;

   int          cycleCnt = 0;
   int          compareCount = 0;
   int          mismatchCount = 0;

   logic [28:0] wordQ[$];
   int          cycQ[$];

   int          e0, rEdge, badY, badX, badT, cnt;
   logic [28:0] w;
   logic [1:0]  expX;

   ycbcr422_packer #(.H_BLOCK(640)) dut (
      .i_clk_74M  (clk),
      .i_rst_n    (rstN),
      .i_de       (de),
      .i_vsync    (vs),
      .i_r        (r),
      .i_g        (g),
      .i_b        (b),
      .i_fifo_full(full),
      .o_fifo_wr  (wr),
      .o_fifo_din (din),
      .o_overflow (ovf)
   );

   // Free-running clock and an edge counter that numbers every rising edge.
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Log every write on the falling edge, well away from the active edge.
   always @(negedge clk) begin
      if (wr === 1'b1) begin
         wordQ.push_back(din);
         cycQ.push_back(cycleCnt);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic deIn, input logic vsIn, input logic [7:0] rIn,
                                input logic [7:0] gIn, input logic [7:0] bIn,
                                input logic fullIn);
      de   = deIn;
      vs   = vsIn;
      r    = rIn;
      g    = gIn;
      b    = bIn;
      full = fullIn;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
   endtask

   task automatic pixel(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
      applyStimulus(1'b1, 1'b0, rr, gg, bb, 1'b0);
   endtask

   task automatic clearLog();
      wordQ.delete();
      cycQ.delete();
   endtask

   function automatic logic [28:0] mkWord(input logic [1:0] x, input logic [10:0] line,
                                          input logic [7:0] luma, input logic [7:0] chroma);
      return {x, line, luma, chroma};
   endfunction

   function automatic logic [28:0] wordAt(input int idx);
      if (idx >= 0 && idx < int'(wordQ.size())) return wordQ[idx];
      return 29'h1FFF_FFFF;
   endfunction

   function automatic int cycAt(input int idx);
      if (idx >= 0 && idx < int'(cycQ.size())) return cycQ[idx];
      return -1;
   endfunction

   initial begin
      rstN = 1'b0;
      de = 1'b0; vs = 1'b0; r = 8'd0; g = 8'd0; b = 8'd0; full = 1'b0;
      idle(3);
      checkOutput("reset wr", {31'd0, wr}, 32'd0);
      checkOutput("reset din", {3'd0, din}, 32'd0);
      checkOutput("reset ovf", {31'd0, ovf}, 32'd0);
      rstN = 1'b1;
      idle(4);

      // Two white pixels on line 0
      clearLog();
      pixel(8'd255, 8'd255, 8'd255);
      e0 = cycleCnt;
      pixel(8'd255, 8'd255, 8'd255);
      idle(8);
      checkOutput("white count", wordQ.size(), 32'd2);
      checkOutput("white word0", {3'd0, wordAt(0)}, {3'd0, mkWord(2'd0, 11'd0, 8'd235, 8'd128)});
      checkOutput("white word1", {3'd0, wordAt(1)}, {3'd0, mkWord(2'd0, 11'd0, 8'd235, 8'd128)});
      checkOutput("white latency0", cycAt(0) - e0, 32'd4);
      checkOutput("white latency1", cycAt(1) - e0, 32'd5);

      // Red then black on line 1
      clearLog();
      pixel(8'd255, 8'd0, 8'd0);
      pixel(8'd0, 8'd0, 8'd0);
      idle(8);
      checkOutput("redblack count", wordQ.size(), 32'd2);
      checkOutput("red even word", {3'd0, wordAt(0)}, {3'd0, mkWord(2'd0, 11'd1, 8'd82, 8'd184)});
      checkOutput("black odd word", {3'd0, wordAt(1)}, {3'd0, mkWord(2'd0, 11'd1, 8'd16, 8'd109)});

      // Odd-length line on line 2 ending with a red trailing pixel
      clearLog();
      pixel(8'd0, 8'd0, 8'd0);
      e0 = cycleCnt;
      pixel(8'd0, 8'd0, 8'd0);
      pixel(8'd255, 8'd0, 8'd0);
      idle(8);
      checkOutput("trail count", wordQ.size(), 32'd3);
      checkOutput("trail word0", {3'd0, wordAt(0)}, {3'd0, mkWord(2'd0, 11'd2, 8'd16, 8'd128)});
      checkOutput("trail word2", {3'd0, wordAt(2)}, {3'd0, mkWord(2'd0, 11'd2, 8'd82, 8'd240)});
      checkOutput("trail latency", cycAt(2) - e0, 32'd6);

      // Frame start, one short line, then a 1281-pixel grey line
      applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
      applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
      idle(3);
      clearLog();
      repeat (4) pixel(8'd128, 8'd128, 8'd128);
      idle(8);
      w = wordAt(0);
      checkOutput("line after vsync", {21'd0, w[26:16]}, 32'd0);
      clearLog();
      pixel(8'd128, 8'd128, 8'd128);
      e0 = cycleCnt;
      repeat (1280) pixel(8'd128, 8'd128, 8'd128);
      idle(8);
      checkOutput("grey count", wordQ.size(), 32'd1281);
      badY = 0; badX = 0; badT = 0;
      for (int i = 0; i < 1281; i++) begin
         w    = wordAt(i);
         expX = (i < 640) ? 2'd0 : ((i < 1280) ? 2'd1 : 2'd2);
         if (w[26:16] != 11'd1 || w[15:8] != 8'd126) badY++;
         if (w[28:27] != expX) badX++;
         if (cycAt(i) != e0 + 4 + i) badT++;
      end
      checkOutput("grey line/luma errors", badY, 32'd0);
      checkOutput("grey block errors", badX, 32'd0);
      checkOutput("grey timing errors", badT, 32'd0);
      w = wordAt(639);
      checkOutput("col639 block", {30'd0, w[28:27]}, 32'd0);
      w = wordAt(640);
      checkOutput("col640 block", {30'd0, w[28:27]}, 32'd1);
      w = wordAt(1280);
      checkOutput("col1280 block", {30'd0, w[28:27]}, 32'd2);
      checkOutput("col1280 chroma", {24'd0, w[7:0]}, 32'd128);

      // Three full cycles mid-line on line 2
      clearLog();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 1'b0, 8'd128, 8'd128, 8'd128, (i >= 8 && i <= 10));
         if (i == 0) e0 = cycleCnt;
      end
      idle(8);
      checkOutput("full count", wordQ.size(), 32'd17);
      checkOutput("full overflow set", {31'd0, ovf}, 32'd1);
      cnt = 0;
      foreach (cycQ[k]) if (cycQ[k] >= e0 + 8 && cycQ[k] <= e0 + 10) cnt++;
      checkOutput("full window writes", cnt, 32'd0);
      checkOutput("full last write edge", cycAt(16) - e0, 32'd23);
      idle(10);
      checkOutput("overflow sticky", {31'd0, ovf}, 32'd1);
      applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
      idle(4);
      checkOutput("overflow cleared", {31'd0, ovf}, 32'd0);

      // Reset pulse at col 300 while the line continues
      clearLog();
      for (int i = 0; i < 350; i++) begin
         rstN = (i == 300) ? 1'b0 : 1'b1;
         pixel(8'd128, 8'd128, 8'd128);
         if (i == 0) e0 = cycleCnt;
         if (i == 300) begin
            rEdge = cycleCnt;
            checkOutput("wr after reset edge", {31'd0, wr}, 32'd0);
         end
      end
      rstN = 1'b1;
      idle(8);
      cnt = 0;
      foreach (cycQ[k]) if (cycQ[k] >= rEdge) cnt++;
      checkOutput("writes after reset", cnt, 32'd0);
      checkOutput("writes before reset", wordQ.size(), 32'd296);
      clearLog();
      pixel(8'd255, 8'd0, 8'd0);
      pixel(8'd0, 8'd0, 8'd0);
      idle(8);
      checkOutput("post-reset count", wordQ.size(), 32'd2);
      checkOutput("post-reset even", {3'd0, wordAt(0)}, {3'd0, mkWord(2'd0, 11'd0, 8'd82, 8'd184)});
      checkOutput("post-reset odd", {3'd0, wordAt(1)}, {3'd0, mkWord(2'd0, 11'd0, 8'd16, 8'd109)});

      // vsync rising together with the end of line 1
      pixel(8'd128, 8'd128, 8'd128);
      pixel(8'd128, 8'd128, 8'd128);
      applyStimulus(1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 1'b0);
      idle(4);
      clearLog();
      pixel(8'd128, 8'd128, 8'd128);
      pixel(8'd128, 8'd128, 8'd128);
      idle(8);
      checkOutput("coincident count", wordQ.size(), 32'd2);
      w = wordAt(0);
      checkOutput("coincident line", {21'd0, w[26:16]}, 32'd0);

      // Line counter saturation
      repeat (2045) begin
         pixel(8'd128, 8'd128, 8'd128);
         idle(1);
      end
      idle(8);
      clearLog();
      pixel(8'd128, 8'd128, 8'd128);
      pixel(8'd128, 8'd128, 8'd128);
      idle(8);
      w = wordAt(1);
      checkOutput("line 2046", {21'd0, w[26:16]}, 32'd2046);
      repeat (5) begin
         pixel(8'd128, 8'd128, 8'd128);
         idle(1);
      end
      idle(8);
      clearLog();
      pixel(8'd128, 8'd128, 8'd128);
      pixel(8'd128, 8'd128, 8'd128);
      idle(8);
      w = wordAt(0);
      checkOutput("line saturated", {21'd0, w[26:16]}, 32'd2047);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/ycbcr422_packer.md
# ycbcr422_packer

Transmit-side packer that converts the decoded 24-bit RGB pixel stream into 29-bit YCbCr 4:2:2 FIFO words. Each word carries the pixel's block index, line number, luma and one chroma sample. Sits directly upstream of the pixel FIFO that `datacontroller` drains at 74.25 MHz. Handles line/frame counting, chroma pair averaging and FIFO back-pressure (drop with sticky flag).

## Interface
- `H_BLOCK`, default 640: pixels per horizontal block; sets `x_count` granularity.
- `i_clk_74M`  in  1   74.25 MHz pixel clock; the only clock.
- `i_rst_n`  in  1   reset; synchronous, active-low.
- `i_de`  in  1   data enable; high during active pixels.
- `i_vsync`  in  1   vertical sync, active high; rising edge marks frame start.
- `i_r`, `i_g`, `i_b`  in  8 each   pixel components, valid when `i_de`=1.
- `i_fifo_full`  in  1   downstream FIFO full.
- `o_fifo_wr`  out  1   FIFO write strobe.
- `o_fifo_din`  out  29   `{x_count[1:0], y_count[10:0], Y[7:0], C[7:0]}`.
- `o_overflow`  out  1   sticky: a word was dropped this frame.

## Operation
- Column counter `col` (11 b):
  - Cleared on the rising edge of `i_de`.
  - +1 per active pixel; saturates at 2047.
- Block index `x_count` = min(col / `H_BLOCK`, 3).
  - Implemented as an intra-block counter plus a 2-bit block counter; no divider.
- Line counter `y_count` (11 b):
  - Cleared on the rising edge of `i_vsync`.
  - +1 on each falling edge of `i_de`; saturates at 2047.
- After reset, input is ignored until `i_de` has been sampled low at least once. Partial lines are never emitted.
- Colour conversion uses signed 18-bit intermediates and an arithmetic (floor) shift:
  - Y = ((66R + 129G + 25B + 128) >>> 8) + 16
  - Cb = ((−38R − 74G + 112B + 128) >>> 8) + 128
  - Cr = ((112R − 94G − 18B + 128) >>> 8) + 128
  - All three are clipped to 0..255.
- 4:2:2 pairing: pixels pair as (even col, odd col).
  - Even word C = (Cr0 + Cr1 + 1) >> 1.
  - Odd word C = (Cb0 + Cb1 + 1) >> 1.
  - Sums are 9-bit.
- Trailing unpaired even pixel (line of odd length): emitted alone with C = its own Cr.
- Back-pressure: `o_fifo_wr` = word_valid & ~`i_fifo_full`.
  - A valid word presented while full is dropped, never stalled, and sets `o_overflow`.
  - `o_overflow` clears on the `i_vsync` rising edge. If a drop occurs in the same cycle as that edge, the set wins.
- Simultaneous `i_vsync` rise and `i_de` fall: `y_count` becomes 0; no increment that cycle.

## Timing
- Pipeline stages:
  - S1: input register.
  - S2: products/sums, then shift/offset/clip to Y/Cb/Cr with col/line tags.
  - S3: pair hold register and output register.
- Latency: a pixel sampled at edge t appears on `o_fifo_din`/`o_fifo_wr` after edge t+4. This holds for even, odd and trailing pixels.
- Throughput: one word per clock, sustained across the whole line; no bubbles between pairs.
- `o_fifo_din` holds its last value when `o_fifo_wr`=0.
- Reset (`i_rst_n`=0 at an edge), all synchronous:
  - `o_fifo_wr`=0, `o_fifo_din`=0, `o_overflow`=0.
  - Counters are zeroed.
  - All pipeline valid bits are cleared; any pixels in flight mid-line are discarded.
  - The post-reset wait for `i_de` low applies.

## Test plan
1. Two white pixels (255,255,255) on line 0 -> two writes, each `{0, 0, Y=235, C=128}`; first write 4 clocks after the first pixel is sampled.
2. Pair red (255,0,0) then black (0,0,0) -> even word Y=82, C=184; odd word Y=16, C=109.
3. Line of 1281 grey pixels (128,128,128) after one vsync and one prior line:
   - 1281 consecutive writes, all with y_count=1 and Y=126.
   - x_count=0 for col 0..639, 1 for 640..1279, 2 for col 1280.
   - Last word's C is its own Cr (128).
4. `i_fifo_full`=1 for 3 cycles mid-line:
   - Exactly 3 words missing, no stall, `o_overflow`=1.
   - `o_overflow` stays 1 until the next `i_vsync` rise, then 0.
5. `i_rst_n` low for 1 cycle at col 300 with `i_de` still high:
   - `o_fifo_wr`=0 from the next edge.
   - No writes for the rest of that line.
   - The next line emits from col 0 with y_count=0.
6. `i_vsync` rise coincident with an `i_de` fall -> y_count=0 on the next line; 2048+ lines without vsync -> y_count saturates at 2047.
